// File: rtl/sht40_responder.sv
`timescale 1ns/1ps
// SHT40 emulator: I2C target that accepts a measurement command by write and
// returns T_MSB, T_LSB, CRC, RH_MSB, RH_LSB, CRC on read.
module sht40_responder #(
  parameter logic [6:0]  I2C_ADDR    = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter logic [15:0] MEAS_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  input  logic [15:0] temp_value,
  input  logic [15:0] rh_value,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_e;

  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0]  crc;
    logic [15:0] d;
    logic        fb;
    crc = 8'hFF;
    d   = data;
    for (int i = 0; i < 16; i++) begin
      fb  = crc[7] ^ d[15];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
      d   = {d[14:0], 1'b0};
    end
    return crc;
  endfunction

  function automatic logic [7:0] buf_byte(input logic [47:0] b, input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = b[47:40];
      3'd1:    r = b[39:32];
      3'd2:    r = b[31:24];
      3'd3:    r = b[23:16];
      3'd4:    r = b[15:8];
      3'd5:    r = b[7:0];
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  logic [2:0]  scl_q, sda_q;
  logic        scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, addr_ok_s;
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  tx_rem_q, tx_rem_d;
  logic [2:0]  byte_idx_q, byte_idx_d, next_idx_s;
  logic [7:0]  next_byte_s;
  logic        is_read_q, is_read_d, ack_q, ack_d, cmd_done_q, cmd_done_d;
  logic        drive_q, drive_d, cmd_valid_q, cmd_valid_d;
  logic        busy_q, busy_d, ready_q, ready_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [15:0] meas_cnt_q, meas_cnt_d;
  logic [47:0] tx_buf_q, tx_buf_d;

  assign scl_s       = scl_q[1];
  assign sda_s       = sda_q[1];
  assign scl_rise_s  = scl_q[1] & ~scl_q[2];
  assign scl_fall_s  = ~scl_q[1] & scl_q[2];
  assign start_s     = scl_s & ~sda_q[1] & sda_q[2];
  assign stop_s      = scl_s & sda_q[1] & ~sda_q[2];
  assign addr_ok_s   = (shift_q[7:1] == I2C_ADDR) && (!shift_q[0] || (ready_q && !busy_q));
  // Index 6 is the saturated dummy slot that reads as 8'hFF.
  assign next_idx_s  = (byte_idx_q == 3'd6) ? 3'd6 : byte_idx_q + 3'd1;
  assign next_byte_s = buf_byte(tx_buf_q, next_idx_s);

  assign sda_drive_low = drive_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_byte      = cmd_byte_q;
  assign busy          = busy_q;

  // Two-flop synchronizers plus previous-value stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      tx_rem_q    <= 7'h7F;
      byte_idx_q  <= 3'd0;
      is_read_q   <= 1'b0;
      ack_q       <= 1'b0;
      cmd_done_q  <= 1'b0;
      drive_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      meas_cnt_q  <= 16'd0;
      tx_buf_q    <= 48'h0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_rem_q    <= tx_rem_d;
      byte_idx_q  <= byte_idx_d;
      is_read_q   <= is_read_d;
      ack_q       <= ack_d;
      cmd_done_q  <= cmd_done_d;
      drive_q     <= drive_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      meas_cnt_q  <= meas_cnt_d;
      tx_buf_q    <= tx_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_rem_d    = tx_rem_q;
    byte_idx_d  = byte_idx_q;
    is_read_d   = is_read_q;
    ack_d       = ack_q;
    cmd_done_d  = cmd_done_q;
    drive_d     = drive_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    meas_cnt_d  = meas_cnt_q;
    tx_buf_d    = tx_buf_q;

    if (busy_q && meas_cnt_q <= 16'd1) begin
      busy_d   = 1'b0;
      ready_d  = 1'b1;
      tx_buf_d = {temp_value, crc8(temp_value), rh_value, crc8(rh_value)};
    end else if (busy_q) begin
      meas_cnt_d = meas_cnt_q - 16'd1;
    end else begin
      meas_cnt_d = 16'd0;
    end

    // Bus handling comes after the counter so a new command restarts it.
    if (start_s) begin
      state_d    = ADDR;
      bit_cnt_d  = 4'd0;
      cmd_done_d = 1'b0;
      drive_d    = 1'b0;
    end else if (stop_s) begin
      state_d = IDLE;
      drive_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, CMD: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR && addr_ok_s) begin
              drive_d   = 1'b1;
              is_read_d = shift_q[0];
              state_d   = ADDR_ACK;
            end else if (state_q == CMD && !cmd_done_q) begin
              drive_d     = 1'b1;
              state_d     = CMD_ACK;
              cmd_done_d  = 1'b1;
              cmd_valid_d = 1'b1;
              cmd_byte_d  = shift_q;
              if (shift_q == MEAS_CMD) begin
                busy_d     = 1'b1;
                ready_d    = 1'b0;
                meas_cnt_d = MEAS_CYCLES;
              end else begin
                busy_d = busy_q;
              end
            end else begin
              state_d = WAIT_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s && is_read_q) begin
            state_d    = TX_BYTE;
            byte_idx_d = 3'd0;
            bit_cnt_d  = 4'd0;
            tx_rem_d   = tx_buf_q[46:40];
            drive_d    = ~tx_buf_q[47];
          end else if (scl_fall_s) begin
            state_d   = CMD;
            bit_cnt_d = 4'd0;
            drive_d   = 1'b0;
          end else begin
            drive_d = drive_q;
          end
        end
        CMD_ACK: begin
          if (scl_fall_s) begin
            state_d   = CMD;
            bit_cnt_d = 4'd0;
            drive_d   = 1'b0;
          end else begin
            drive_d = drive_q;
          end
        end
        TX_BYTE: begin
          if (scl_fall_s && bit_cnt_q == 4'd7) begin
            state_d   = TX_ACK;
            bit_cnt_d = 4'd0;
            drive_d   = 1'b0;
          end else if (scl_fall_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            drive_d   = ~tx_rem_q[6];
            tx_rem_d  = {tx_rem_q[5:0], 1'b1};
          end else begin
            drive_d = drive_q;
          end
        end
        TX_ACK: begin
          if (scl_rise_s) begin
            ack_d = ~sda_s;
            // Master has answered the last real byte: this read consumed the data.
            if (byte_idx_q == 3'd5) begin
              ready_d = 1'b0;
            end else begin
              ready_d = ready_q;
            end
          end else if (scl_fall_s && ack_q) begin
            state_d    = TX_BYTE;
            byte_idx_d = next_idx_s;
            bit_cnt_d  = 4'd0;
            tx_rem_d   = next_byte_s[6:0];
            drive_d    = ~next_byte_s[7];
          end else if (scl_fall_s) begin
            state_d = WAIT_STOP;
            drive_d = 1'b0;
          end else begin
            drive_d = drive_q;
          end
        end
        IDLE, WAIT_STOP: begin
          drive_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          drive_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_responder.sv
`timescale 1ns/1ps
// Directed bench for sht40_responder: an I2C master task set drives the bus,
// and a per-cycle compare process checks outputs against a spec-level model.
module tb_sht40_responder;

  localparam int          H      = 16;
  localparam logic [15:0] MEAS_N = 16'd1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic [15:0] temp_value, rh_value;
  logic        sda_drive_low, cmd_valid, busy;
  logic [7:0]  cmd_byte;

  int          total = 0;
  int          bad = 0;
  int          m_remaining = 0;
  bit          m_ready = 1'b0;
  logic [7:0]  m_tx [6];
  logic [7:0]  lit [6];
  logic [7:0]  rx [8];
  logic [7:0]  exp_cmd = 8'h00;
  int          cv_count = 0;
  bit          no_drive_win = 1'b0;
  logic        prev_drv = 1'b0;
  logic        prev_cv = 1'b0;
  int          busy_run = 0;
  int          last_busy_run = 0;

  assign sda_line = sda_m & ~sda_drive_low;

  sht40_responder dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
    .sda_drive_low(sda_drive_low), .temp_value(temp_value), .rh_value(rh_value),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC as polynomial remainder of the init-adjusted message times x^8.
  function automatic logic [7:0] ref_crc(input logic [15:0] d);
    logic [23:0] v;
    v = {d ^ 16'hFF00, 8'h00};
    for (int i = 23; i >= 8; i--)
      if (v[i]) v = v ^ (24'h000131 << (i - 8));
    return v[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_remaining = 0;
      m_ready     = 1'b0;
      busy_run    = 0;
    end else begin
      if (prev_cv) chk("cv_one_cycle", 32'(cmd_valid), 32'd0);
      if (cmd_valid) begin
        cv_count++;
        chk("cv_cmd_byte", 32'(cmd_byte), 32'(exp_cmd));
        chk("cv_with_ack", 32'(sda_drive_low), 32'd1);
        if (exp_cmd == 8'hFD) begin
          m_remaining = int'(MEAS_N);
          m_ready     = 1'b0;
        end
      end
      chk("busy_model", 32'(busy), 32'(m_remaining > 0));
      if (m_remaining > 0) begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_tx[0] = temp_value[15:8];
          m_tx[1] = temp_value[7:0];
          m_tx[2] = ref_crc(temp_value);
          m_tx[3] = rh_value[15:8];
          m_tx[4] = rh_value[7:0];
          m_tx[5] = ref_crc(rh_value);
          m_ready = 1'b1;
        end
      end
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        last_busy_run = busy_run;
        busy_run = 0;
      end
      if (sda_drive_low !== prev_drv) chk("drv_change_scl_low", 32'(scl_m), 32'd0);
      if (no_drive_win) chk("no_drive", 32'(sda_drive_low), 32'd0);
    end
    prev_drv = sda_drive_low;
    prev_cv  = cmd_valid;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; clks(H / 2);
    scl_m = 1'b1; clks(H);
    sda_m = 1'b0; clks(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop;
    clks(H / 2); sda_m = 1'b0;
    clks(H / 2); scl_m = 1'b1;
    clks(H);     sda_m = 1'b1;
    clks(H);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    clks(H / 2); sda_m = b;
    clks(H / 2); scl_m = 1'b1;
    clks(H - 1);
    @(negedge clk) r = sda_line;
    @(posedge clk) scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    logic [7:0] t;
    logic       r;
    t = b;
    for (int i = 0; i < 8; i++) begin
      clock_bit(t[7], r);
      t = {t[6:0], 1'b0};
    end
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clock_bit(~mack, r);
  endtask

  task automatic do_read(input int n, output bit ack);
    i2c_start;
    write_byte(8'h89, ack);
    if (ack)
      for (int k = 0; k < n; k++) read_byte(k != n - 1, rx[k]);
    i2c_stop;
    if (ack && n >= 6) m_ready = 1'b0;
  endtask

  task automatic check_read(input string tag, input int n);
    bit ack, exp_ack;
    exp_ack = m_ready && (m_remaining == 0);
    do_read(n, ack);
    chk({tag, "_addr_ack"}, 32'(ack), 32'(exp_ack));
    if (ack)
      for (int k = 0; k < n; k++)
        chk($sformatf("%s_rd%0d", tag, k), 32'(rx[k]), 32'((k < 6) ? m_tx[k] : 8'hFF));
  endtask

  task automatic write_cmd(input string tag, input logic [7:0] c);
    bit ack;
    int cv0;
    cv0     = cv_count;
    exp_cmd = c;
    i2c_start;
    write_byte(8'h88, ack); chk({tag, "_waddr_ack"}, 32'(ack), 32'd1);
    write_byte(c, ack);     chk({tag, "_cmd_ack"}, 32'(ack), 32'd1);
    i2c_stop;
    chk({tag, "_cv_pulses"}, 32'(cv_count - cv0), 32'd1);
    chk({tag, "_cmd_byte"}, 32'(cmd_byte), 32'(c));
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_done", 32'(busy), 32'd0);
    clks(2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ack;
    int cv0;
    lit = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93};
    temp_value = 16'hBEEF;
    rh_value   = 16'h6666;
    clks(5);
    @(negedge clk);
    chk("rst_sda", 32'(sda_drive_low), 32'd0);
    chk("rst_cv", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_byte", 32'(cmd_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("crc_beef", 32'(ref_crc(temp_value)), 32'h92);
    chk("crc_6666", 32'(ref_crc(rh_value)), 32'h93);
    rst = 1'b0;
    clks(4);

    // Measurement command, then a read attempt while busy.
    write_cmd("a", 8'hFD);
    chk("b_busy_high", 32'(busy), 32'd1);
    no_drive_win = 1'b1;
    check_read("b", 6);
    no_drive_win = 1'b0;
    wait_idle;
    chk("a_busy_len", 32'(last_busy_run), 32'(MEAS_N));

    // Full read, then data must be consumed.
    check_read("c", 6);
    for (int k = 0; k < 6; k++) chk($sformatf("c_lit%0d", k), 32'(rx[k]), 32'(lit[k]));
    check_read("c_again", 6);

    // Non-measurement command leaves busy low.
    write_cmd("e0", 8'hE0);
    @(negedge clk);
    chk("e0_not_busy", 32'(busy), 32'd0);

    // Wrong address, then repeated START with a valid command.
    cv0 = cv_count;
    no_drive_win = 1'b1;
    i2c_start;
    write_byte(8'h8A, ack);
    chk("d_wrong_addr_nack", 32'(ack), 32'd0);
    no_drive_win = 1'b0;
    chk("d_no_cv", 32'(cv_count - cv0), 32'd0);
    exp_cmd = 8'hFD;
    i2c_start;
    write_byte(8'h88, ack); chk("d_addr_ack", 32'(ack), 32'd1);
    write_byte(8'hFD, ack); chk("d_cmd_ack", 32'(ack), 32'd1);
    i2c_stop;
    chk("d_cv_pulses", 32'(cv_count - cv0), 32'd1);
    wait_idle;

    // Partial read keeps data; next read returns it again plus dummy 0xFF.
    check_read("p", 2);
    chk("p_lit0", 32'(rx[0]), 32'hBE);
    chk("p_lit1", 32'(rx[1]), 32'hEF);
    check_read("p_full", 7);
    for (int k = 0; k < 6; k++) chk($sformatf("p_lit%0d", k + 2), 32'(rx[k]), 32'(lit[k]));
    chk("p_dummy", 32'(rx[6]), 32'hFF);

    // Extra write byte NACKed; restart while busy; inputs change before completion.
    exp_cmd = 8'hFD;
    i2c_start;
    write_byte(8'h88, ack); chk("f_addr_ack", 32'(ack), 32'd1);
    write_byte(8'hFD, ack); chk("f_cmd_ack", 32'(ack), 32'd1);
    write_byte(8'h00, ack); chk("f_extra_nack", 32'(ack), 32'd0);
    i2c_stop;
    temp_value = 16'h1234;
    rh_value   = 16'hABCD;
    clks(200);
    write_cmd("f_restart", 8'hFD);
    wait_idle;
    check_read("f", 6);
    chk("f_lit0", 32'(rx[0]), 32'h12);
    chk("f_lit4", 32'(rx[4]), 32'hCD);

    // Reset while driving bit 7 (0) of T_MSB.
    write_cmd("g", 8'hFD);
    wait_idle;
    i2c_start;
    write_byte(8'h89, ack);
    chk("g_addr_ack", 32'(ack), 32'd1);
    clks(H / 2);
    @(negedge clk);
    chk("g_drive_bit7", 32'(sda_drive_low), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("g_rst_release", 32'(sda_drive_low), 32'd0);
    chk("g_rst_busy", 32'(busy), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(3);
    @(negedge clk) rst = 1'b0;
    clks(4);
    check_read("g_after_rst", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sht40_responder.md
Name: sht40_responder

Overview:
- Synthesizable SHT40 sensor emulator: the I2C responder (target) that answers our I2C master and SHT40 receive/CRC path.
- Accepts the measurement command by write and returns 6 bytes on read: T_MSB, T_LSB, CRC, RH_MSB, RH_LSB, CRC.
- Used in-fabric for closed-loop bring-up and regression of the master side without a physical sensor.

Parameters:
- I2C_ADDR, 7'h44, 7-bit target address.
- MEAS_CMD, 8'hFD, command that triggers a measurement (high precision).
- MEAS_CYCLES, 16'd1000, clk cycles the measurement stays busy before data is readable.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_drive_low  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- temp_value  input  16  raw temperature word, sampled at measurement completion.
- rh_value  input  16  raw humidity word, sampled at measurement completion.
- cmd_valid  output  1  one-cycle pulse when a command byte has been ACKed.
- cmd_byte  output  8  last received command byte; held until the next command.
- busy  output  1  high while a measurement is in progress.

Behaviour:
- Reset values: sda_drive_low=0, cmd_valid=0, cmd_byte=8'h00, busy=0, data_ready=0, FSM=IDLE, 6-byte tx buffer all 8'h00.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer.
  - Edges are detected on the synced signals against their previous-cycle value.
- START: synced SDA falls while synced SCL is high. Enter ADDR from any state, including mid-byte (repeated START); clear the bit counter.
- STOP: synced SDA rises while synced SCL is high. Go to IDLE and release SDA.
- Data timing:
  - Receive bits are sampled on the detected SCL rise, MSB first.
  - The responder changes sda_drive_low only in the cycle an SCL fall is detected, never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- ADDR: shift 8 bits. On the 8th SCL fall:
  - Address mismatch → WAIT_STOP, no drive.
  - Match with R/W=0 → ACK.
  - Match with R/W=1 and data_ready=1 and busy=0 → ACK.
  - Match with R/W=1 otherwise → NACK (release), then WAIT_STOP.
- ADDR_ACK: drive low for one SCL period; release on the following SCL fall.
  - Write → CMD.
  - Read → TX_BYTE with byte index 0; drive bit 7 on that same fall.
- CMD: shift 8 bits, then ACK.
  - cmd_valid pulses and cmd_byte updates in the cycle the ACK is asserted.
  - If byte==MEAS_CMD: busy=1, data_ready=0, load the MEAS_CYCLES counter.
  - A MEAS_CMD received while busy restarts the counter.
- Further write bytes after the command: NACK, then WAIT_STOP.
- Measurement completion: the counter decrements each clk. At zero:
  - Snapshot temp_value and rh_value into the tx buffer.
  - Compute both CRCs.
  - Set busy=0 and data_ready=1.
- CRC: CRC-8, poly 0x31, init 0xFF, no reflection, no final XOR, over {MSB, LSB}. The implementation may use a combinational function or a sequential 16-step loop; it must be finished before data_ready=1.
- TX_BYTE:
  - Drive low when the current bit is 0; release when it is 1.
  - Advance the bit on each SCL fall.
  - After bit 0's SCL fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on SCL rise.
  - ACK (0) with index<5 → next byte.
  - NACK → WAIT_STOP.
  - ACK after byte 5 → keep releasing SDA (master reads 8'hFF) and stay in TX_BYTE with an index-saturated dummy.
- data_ready clears after a read where all 6 bytes were ACKed or NACKed through byte 5. A partial read leaves data_ready=1.
- Reset mid-transfer: SDA is released immediately (asynchronous), the FSM returns to IDLE, and the measurement is aborted.
- No clock stretching; SCL is never driven.

Test Plan:
- rst asserted mid-TX_BYTE while driving low → sda_drive_low=0 in the same cycle; busy=0, data_ready=0.
- Write 0x88 (addr 0x44, W), 0xFD; temp_value=16'hBEEF, rh_value=16'h6666 → both bytes ACKed; cmd_valid pulses once with cmd_byte=8'hFD; busy high for exactly MEAS_CYCLES clks.
- After busy falls: read 0x89 with 6 bytes, master ACK×5 then NACK → master receives BE EF 92 66 66 93; STOP returns to IDLE.
- Read 0x89 while busy=1 → address NACKed, SDA never driven until STOP.
- Write to address 0x45 → no ACK, no cmd_valid; then a repeated START with 0x88, 0xFD → accepted normally.
- Read with master NACK after byte 1 (0xEF) → SDA released; data_ready stays 1; the next full read returns the same 6 bytes.
